// File: rtl/instr_encoder_loader.sv
// Packs symbolic controller instruction fields into 32-bit machine words and streams them into imem.
// One word per accepted beat. Illegal encodings or running past MAX_WORDS abort the load with an error code.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [3:0]            cond,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rn,
    input  logic [3:0]            rd,
    input  logic [11:0]           src2,
    input  logic [23:0]           imm24,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;
    localparam logic [ADDR_WIDTH:0]   MAX_CNT  = (ADDR_WIDTH + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH:0]     count_reg, count_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic [1:0]              err_code_reg, err_code_next;
    logic                    last_reg, last_next;

    logic                    dp_legal;
    logic                    legal;
    logic [31:0]             encoded;

    // Only the opcode set the controller decodes is accepted; funct[5]=I and funct[0]=S pass through.
    always_comb begin
        dp_legal = 1'b0;
        case (funct[4:1])
            4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1111, 4'b0001: dp_legal = 1'b1;
            default: dp_legal = 1'b0;
        endcase

        case (op)
            2'b00:   legal = dp_legal;
            2'b01:   legal = (funct == 6'b011001) || (funct == 6'b011000);
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (cond == 4'hF) begin
            legal = 1'b0;
        end

        if (op == 2'b10) begin
            encoded = {cond, 2'b10, 2'b10, imm24};
        end else begin
            encoded = {cond, op, funct, rn, rd, src2};
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        err_code_next = err_code_reg;
        last_next     = last_reg;

        in_ready = (state_reg == S_LOAD);
        mem_we   = (state_reg == S_WRITE);
        done     = (state_reg == S_DONE);
        error    = (state_reg == S_ERR);

        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next    = S_LOAD;
                    count_next    = '0;
                    addr_next     = BASE;
                    err_code_next = 2'b00;
                    last_next     = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (legal) begin
                        wdata_next = encoded;
                        last_next  = in_last;
                        state_next = S_WRITE;
                    end else begin
                        err_code_next = 2'b01;
                        state_next    = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    count_next = count_reg + 1'b1;
                    // Saturate so a program ending on the top word leaves mem_addr in range.
                    addr_next  = (addr_reg == ADDR_TOP) ? addr_reg : addr_reg + 1'b1;
                    if (last_reg) begin
                        state_next = S_DONE;
                    end else if (count_next == MAX_CNT) begin
                        err_code_next = 2'b10;
                        state_next    = S_ERR;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            addr_reg     <= BASE;
            wdata_reg    <= '0;
            err_code_reg <= 2'b00;
            last_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            err_code_reg <= err_code_next;
            last_reg     <= last_next;
        end
    end

    assign count     = count_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign err_code  = err_code_reg;

endmodule
